// File: rtl/dpram_arbiter.sv
// Round-robin scheduler that maps up to two of four requesters onto the two ports of a
// dual-port RAM, blocks same-address hazards and steers read data back by requester id.
module dpram_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [3:0]          we,
    input  logic [4*ADDR_W-1:0] addr,
    input  logic [4*DATA_W-1:0] wdata,
    output logic [3:0]          gnt,
    output logic [3:0]          rvalid,
    output logic [4*DATA_W-1:0] rdata,
    output logic                wenable1,
    output logic                wenable2,
    output logic [ADDR_W-1:0]   addr1,
    output logic [ADDR_W-1:0]   addr2,
    output logic [DATA_W-1:0]   data_in1,
    output logic [DATA_W-1:0]   data_in2,
    input  logic [DATA_W-1:0]   data_out1,
    input  logic [DATA_W-1:0]   data_out2,
    output logic [15:0]         conflict_cnt
);

    logic [ADDR_W-1:0] addr_arr  [4];
    logic [DATA_W-1:0] wdata_arr [4];

    for (genvar i = 0; i < 4; i++) begin : g_unpack
        assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
    end

    logic [1:0] ptr_q, ptr_d;
    logic       a_vld, b_vld, hazard_skip;
    logic [1:0] a_idx, b_idx, idx;

    // Read tags travel with the registered command, then sit one more cycle in the
    // return stage while the RAM produces data.
    logic       cmd_rd1_q, cmd_rd2_q, ret_vld1_q, ret_vld2_q;
    logic [1:0] cmd_id1_q, cmd_id2_q, ret_id1_q, ret_id2_q;

    always_comb begin
        a_vld       = 1'b0;
        b_vld       = 1'b0;
        a_idx       = 2'd0;
        b_idx       = 2'd0;
        idx         = 2'd0;
        hazard_skip = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + k[1:0];
            if (req[idx]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = idx;
                end else if (!b_vld) begin
                    // Only requests examined while looking for B can be skipped.
                    if ((addr_arr[idx] == addr_arr[a_idx]) && (we[idx] || we[a_idx])) begin
                        hazard_skip = 1'b1;
                    end else begin
                        b_vld = 1'b1;
                        b_idx = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (!reset) begin
            if (a_vld) gnt[a_idx] = 1'b1;
            if (b_vld) gnt[b_idx] = 1'b1;
        end
        ptr_d = ptr_q;
        if (b_vld) begin
            ptr_d = b_idx + 2'd1;
        end else if (a_vld) begin
            ptr_d = a_idx + 2'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q        <= 2'd0;
            conflict_cnt <= 16'd0;
            wenable1     <= 1'b0;
            wenable2     <= 1'b0;
            addr1        <= '0;
            addr2        <= '0;
            data_in1     <= '0;
            data_in2     <= '0;
            cmd_rd1_q    <= 1'b0;
            cmd_rd2_q    <= 1'b0;
            cmd_id1_q    <= 2'd0;
            cmd_id2_q    <= 2'd0;
            ret_vld1_q   <= 1'b0;
            ret_vld2_q   <= 1'b0;
            ret_id1_q    <= 2'd0;
            ret_id2_q    <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
            if (hazard_skip && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            wenable1   <= a_vld && we[a_idx];
            addr1      <= a_vld ? addr_arr[a_idx] : '0;
            data_in1   <= (a_vld && we[a_idx]) ? wdata_arr[a_idx] : '0;
            cmd_rd1_q  <= a_vld && !we[a_idx];
            cmd_id1_q  <= a_vld ? a_idx : 2'd0;
            wenable2   <= b_vld && we[b_idx];
            addr2      <= b_vld ? addr_arr[b_idx] : '0;
            data_in2   <= (b_vld && we[b_idx]) ? wdata_arr[b_idx] : '0;
            cmd_rd2_q  <= b_vld && !we[b_idx];
            cmd_id2_q  <= b_vld ? b_idx : 2'd0;
            ret_vld1_q <= cmd_rd1_q;
            ret_id1_q  <= cmd_id1_q;
            ret_vld2_q <= cmd_rd2_q;
            ret_id2_q  <= cmd_id2_q;
        end
    end

    // A and B are always distinct requesters, so the two return lanes never collide.
    always_comb begin
        rvalid = 4'b0000;
        rdata  = '0;
        if (ret_vld1_q) begin
            rvalid[ret_id1_q]                   = 1'b1;
            rdata[ret_id1_q*DATA_W +: DATA_W] = data_out1;
        end
        if (ret_vld2_q) begin
            rvalid[ret_id2_q]                   = 1'b1;
            rdata[ret_id2_q*DATA_W +: DATA_W] = data_out2;
        end
    end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Four-requester scheduler in front of the 8x32 dual-port RAM. Accepts up to two transactions per cycle, one per RAM port, using a round-robin pointer. Blocks same-address hazards, registers the RAM-side command signals, and routes the RAM read data back to the requester that issued each read. It sits between the client logic and the dual-port RAM and is the only master of both RAM ports.

## Interface
- DATA_W, 32, data width per requester and per RAM port
- ADDR_W, 3, RAM address width (depth 2**ADDR_W)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  4  request per requester i
- we  in  4  1 = write, 0 = read, per requester
- addr  in  4*ADDR_W  requester i address at bits [i*ADDR_W +: ADDR_W]
- wdata  in  4*DATA_W  requester i write data at [i*DATA_W +: DATA_W]
- gnt  out  4  combinational grant; transfer accepted at the edge where req[i]&gnt[i]
- rvalid  out  4  read data valid for requester i
- rdata  out  4*DATA_W  read data lanes, valid when rvalid[i]
- wenable1, wenable2  out  1  RAM port write enables (registered)
- addr1, addr2  out  ADDR_W  RAM port addresses (registered)
- data_in1, data_in2  out  DATA_W  RAM port write data (registered)
- data_out1, data_out2  in  DATA_W  RAM read data; valid the cycle after the address is presented
- conflict_cnt  out  16  saturating count of cycles in which a hazard suppressed a grant

## Operation
- Arbitration is combinational each cycle. Scan requesters ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- The first active req becomes candidate A and is routed to port 1.
- Each later active req is tested against A:
  - Hazard: same address and at least one of the two is a write.
  - A hazard skips that requester and continues the scan.
  - The first non-hazard requester becomes B and is routed to port 2.
- Read-read to the same address is not a hazard. Both requests are granted.
- gnt has at most 2 bits set. A requester holds req, we, addr and wdata stable until it sees gnt.
- Pointer update: ptr <= (index of the last granted requester + 1) mod 4. ptr is unchanged when nothing is granted.
- At the accepting edge, each granted command is registered onto its port:
  - wenable gets we.
  - addr and data_in are copied from the requester.
  - data_in is 0 for reads.
- An unused port registers wenable=0, addr=0, data_in=0.
- Read return uses a one-stage pipeline per port holding {valid, requester id}, loaded at the accepting edge for reads only.
- rdata lane for id is driven from data_outN while that stage is valid. rvalid[id] is 1 for that cycle.
- Lanes not being returned drive rvalid=0 and rdata=0.
- conflict_cnt increments by 1 in each cycle where at least one active req was skipped because of a hazard. It saturates at 16'hFFFF.

## Timing
- Cycle N: req seen, gnt asserted combinationally.
- Edge end of N: accept. RAM command visible on the port signals during N+1.
- RAM writes or reads at the edge end of N+1.
- Read latency: rvalid and rdata in cycle N+2, a 1-cycle pulse.
- Throughput: 2 transactions per cycle with no hazards.
- Writes visible to reads accepted in a later cycle: a read accepted at N+1 of the same address returns the new data.
- Reset (synchronous):
  - ptr=0, conflict_cnt=0.
  - All RAM-side outputs = 0.
  - Return pipeline cleared, so rvalid=0 and rdata=0 the cycle after the reset edge.
- gnt is forced to 0 while reset=1.
- Reset mid-operation drops in-flight reads: no rvalid for them.
- A requester whose req deasserts before gnt is simply not served. No state is kept for it.

## Test plan
- Reset check: reset high 2 cycles -> all outputs 0, gnt=0 with req=4'hF.
- Write then read: req0 writes 88 to addr 7. Next cycle req0 reads addr 7 -> gnt0 both cycles, rvalid[0]=1 with rdata lane0=88 two cycles after the read grant.
- Dual parallel writes: req1 writes 13 to addr 0 and req2 writes 96 to addr 4 in the same cycle -> both granted, wenable1=wenable2=1 next cycle. Later reads of addr 0 and addr 4 return 13 and 96 on the correct lanes.
- Write-write hazard: req0 and req3 both write addr 6 (99, 55), ptr=0 -> gnt=4'b0001, conflict_cnt=1. Next cycle gnt=4'b1000. A final read of addr 6 returns 55.
- Read-read same address: req1 and req2 read addr 5 -> both granted in one cycle, identical rdata on lanes 1 and 2.
- Fairness and reset mid-flight: all four req held with reads to distinct addresses -> grant pairs {0,1},{2,3},{0,1}. Assert reset in the cycle after a grant -> no rvalid is produced and ptr restarts at 0.
